dmem_responder: RTL and testbench
=================================

// Module: dmem_responder
// PURPOSE
//   Target-side data memory for the single-cycle datapath's load/store port.
//   Accepts one 64-bit doubleword read or write per valid/ready request.
//   Inserts WAIT_STATES cycles of access latency before responding.
//   Returns read data, or an error, over a valid/ready response channel.
//   Sits between the CPU's memory-request stage and the backing storage array.
// PARAMETERS
//   DEPTH_WORDS  256   number of 64-bit doublewords stored; power of two, >=2
//   WAIT_STATES  2     extra cycles between accept and response; 0..15
//   BASE_ADDR    64'h0 byte address of doubleword 0; must be 8-byte aligned
// PORTS
//   CLK        in   1   clock; all state updates on posedge
//   resetl     in   1   reset, synchronous, active-high
//   req_valid  in   1   request present
//   req_ready  out  1   responder can accept; high only in IDLE
//   req_write  in   1   1 = store, 0 = load
//   req_addr   in   64  byte address
//   req_wdata  in   64  store data
//   rsp_valid  out  1   response present
//   rsp_ready  in   1   requester accepts response
//   rsp_rdata  out  64  load data; 0 for stores and for errors
//   rsp_err    out  1   misaligned or out-of-range access
// BEHAVIOUR
// - Reset, when resetl=1 at a posedge:
//   - state <= IDLE; wait counter <= 0.
//   - rsp_valid, rsp_err and rsp_rdata all <= 0.
//   - req_ready = 1 from the first cycle after reset deasserts.
//   - Array contents are not cleared.
// - FSM states are IDLE, WAIT and RESP.
// - IDLE:
//   - req_ready = 1.
//   - On req_valid & req_ready, latch write, addr and wdata, and evaluate the error check.
//   - If WAIT_STATES > 0: go to WAIT with counter = WAIT_STATES-1.
//   - If WAIT_STATES = 0: go directly to RESP.
// - WAIT:
//   - req_ready = 0; the counter decrements each cycle.
//   - When the counter is 0, go to RESP on the next edge.
// - Array access on the edge that enters RESP:
//   - Store: the write commits to the array.
//   - Load: the read is captured into rsp_rdata.
//   - If err is set, there is no write, rsp_rdata = 0 and rsp_err = 1.
// - RESP:
//   - rsp_valid = 1; rsp_rdata and rsp_err are held stable until rsp_valid & rsp_ready.
//   - After that handshake: go to IDLE and clear rsp_valid, rsp_err and rsp_rdata.
// - Latency: accept on edge N gives rsp_valid high after edge N+1+WAIT_STATES.
// - Throughput: there is one bubble cycle in IDLE between a response handshake and the next accept.
// - Error check:
//   - err = (addr[2:0] != 0) | ((addr - BASE_ADDR) >> 3 >= DEPTH_WORDS).
//   - The subtraction is 64-bit unsigned, so an address below BASE_ADDR wraps to a large value and flags err.
// - Index: idx = (addr - BASE_ADDR)[3+$clog2(DEPTH_WORDS)-1:3].
// - Boundary cases:
//   - Last word (idx = DEPTH_WORDS-1) is legal.
//   - idx = DEPTH_WORDS gives err.
//   - req_valid held high during WAIT/RESP is ignored; it is re-evaluated in IDLE.
//   - req_* inputs may change after the accept edge without effect, because they are latched.
//   - rsp_ready held high is legal; RESP then lasts exactly one cycle.
// - Reset during WAIT: the pending store is discarded and never commits.
// - Reset on the edge that would enter RESP: reset wins and no write commits.
// STRUCTURE
// - Shared package dmem_pkg:
//   - state typedef {IDLE, WAIT, RESP}.
//   - DWORD_BYTES = 8.
//   - ALIGN_MASK = 3'b111.
// - Sub-module dmem_array:
//   - DEPTH_WORDS x 64 storage, one synchronous write port, one synchronous read port.
//   - Has no reset.
// - Top level holds the FSM, wait counter, request latches, error check and response registers.
// TESTING
// - T1, load after reset (WAIT_STATES=2, preload word 5 = 64'hDEAD_BEEF_0000_0005):
//   - Stimulus: load addr 0x28 accepted at edge N.
//   - Required: rsp_valid rises after edge N+3, rdata = preload, err = 0.
// - T2, store then load:
//   - Stimulus: store 64'h1234 to 0x10, then load 0x10.
//   - Required: the load returns 64'h1234; rdata = 0 on the store response.
// - T3, misaligned store:
//   - Stimulus: store 0xFF to 0x13.
//   - Required: err = 1, rdata = 0.
//   - Required: a follow-up load of 0x10 shows the old value unchanged.
// - T4, range edges (DEPTH 256, BASE 0):
//   - Required: load 0x7F8 gives err = 0; load 0x800 gives err = 1.
//   - Required (BASE 0x1000): load 0x0FF8 gives err = 1 (wrap case).
// - T5, backpressure:
//   - Stimulus: rsp_ready held 0 for 5 cycles.
//   - Required: rsp_valid, rdata and err stay stable, req_ready stays 0, and a second req_valid is not accepted.
// - T6, reset mid-WAIT:
//   - Stimulus: store 64'hAA to 0x8; assert resetl one cycle after accept.
//   - Required: a later load of 0x8 returns the pre-store value.
//   - Required: rsp_valid = 0 and req_ready = 1 after reset.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder.
//   state_e      : responder FSM states (IDLE, WAIT, RESP)
//   DWORD_BYTES  : bytes per stored doubleword
//   ALIGN_MASK   : low address bits that must be zero for a doubleword access
//   addr_err()   : misalignment / out-of-range check for a byte address
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    localparam int         DWORD_BYTES = 8;
    localparam int         DWORD_SHIFT = $clog2(DWORD_BYTES);
    localparam logic [2:0] ALIGN_MASK  = 3'b111;

    // The offset subtraction is unsigned 64-bit, so an address below the
    // base wraps to a huge word offset and is rejected as out of range.
    function automatic logic addr_err(input logic [63:0] addr,
                                      input logic [63:0] base,
                                      input int          depth_words);
        logic [63:0] off;
        off = addr - base;
        return ((addr[2:0] & ALIGN_MASK) != 3'b000) ||
               ((off >> DWORD_SHIFT) >= 64'(depth_words));
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Doubleword storage array: DEPTH_WORDS x 64 bits.
//   CLK      in  clock
//   we_i     in  write enable, write commits on posedge
//   waddr_i  in  word index for the write
//   wdata_i  in  write data
//   re_i     in  read enable, read data registered on posedge
//   raddr_i  in  word index for the read
//   rdata_o  out registered read data, holds until the next enabled read
module dmem_array #(
    parameter int DEPTH_WORDS = 256,
    parameter int AW          = $clog2(DEPTH_WORDS)
) (
    input  logic          CLK,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [63:0]   wdata_i,
    input  logic          re_i,
    input  logic [AW-1:0] raddr_i,
    output logic [63:0]   rdata_o
);

    logic [63:0] mem_q [DEPTH_WORDS];
    logic [63:0] rdata_q;

    // NOTE: the storage and its read register carry no reset; clearing a
    // RAM needs a multi-cycle sequence and would stop it mapping to memory macros.
    always_ff @(posedge CLK) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Target-side data memory for the load/store port. One 64-bit doubleword
// read or write per valid/ready request, WAIT_STATES cycles of latency,
// response (read data or error) over a valid/ready channel.
//   CLK        in  clock, all state on posedge
//   resetl     in  synchronous reset, active high
//   req_valid  in  request present
//   req_ready  out accepting requests (IDLE only)
//   req_write  in  1 = store, 0 = load
//   req_addr   in  byte address
//   req_wdata  in  store data
//   rsp_valid  out response present
//   rsp_ready  in  requester takes the response
//   rsp_rdata  out load data, 0 for stores and errors
//   rsp_err    out misaligned or out-of-range access
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int          DEPTH_WORDS = 256,
    parameter int          WAIT_STATES = 2,
    parameter logic [63:0] BASE_ADDR   = 64'h0
) (
    input  logic        CLK,
    input  logic        resetl,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [63:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int AW = $clog2(DEPTH_WORDS);

    state_e        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic          wr_q, wr_d;
    logic          err_q, err_d;
    logic [AW-1:0] idx_q, idx_d;
    logic [63:0]   wdata_q, wdata_d;
    logic          req_ready_q, req_ready_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic          rsp_err_q, rsp_err_d;
    logic          rsp_dat_q, rsp_dat_d;

    logic          live_err;
    logic [AW-1:0] live_idx;
    logic          xfer_wr, xfer_err;
    logic [AW-1:0] xfer_idx;
    logic [63:0]   xfer_wdata;
    logic          enter_resp;
    logic          arr_we, arr_re;
    logic [63:0]   arr_rdata;

    assign live_err = addr_err(req_addr, BASE_ADDR, DEPTH_WORDS);
    assign live_idx = AW'((req_addr - BASE_ADDR) >> DWORD_SHIFT);

    // With no wait states the array is accessed on the accept edge itself,
    // before the latches hold the request, so take the live inputs in IDLE.
    always_comb begin
        if (state_q == IDLE) begin
            xfer_wr    = req_write;
            xfer_err   = live_err;
            xfer_idx   = live_idx;
            xfer_wdata = req_wdata;
        end else begin
            xfer_wr    = wr_q;
            xfer_err   = err_q;
            xfer_idx   = idx_q;
            xfer_wdata = wdata_q;
        end
    end

    // NOTE: every signal written here gets a default first, so no path
    // leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        wr_d        = wr_q;
        err_d       = err_q;
        idx_d       = idx_q;
        wdata_d     = wdata_q;
        req_ready_d = req_ready_q;
        rsp_valid_d = rsp_valid_q;
        rsp_err_d   = rsp_err_q;
        rsp_dat_d   = rsp_dat_q;
        enter_resp  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (req_valid && req_ready_q) begin
                    wr_d        = req_write;
                    err_d       = live_err;
                    idx_d       = live_idx;
                    wdata_d     = req_wdata;
                    req_ready_d = 1'b0;
                    if (WAIT_STATES == 0) begin
                        state_d    = RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = 4'(WAIT_STATES - 1);
                    end
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d    = RESP;
                    enter_resp = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                // The synchronous read lands on the entering edge, so
                // rsp_valid rises one edge later once the data is in place.
                if (!rsp_valid_q) begin
                    rsp_valid_d = 1'b1;
                end else if (rsp_ready) begin
                    state_d     = IDLE;
                    req_ready_d = 1'b1;
                    rsp_valid_d = 1'b0;
                    rsp_err_d   = 1'b0;
                    rsp_dat_d   = 1'b0;
                end
            end
            default: begin
                state_d     = IDLE;
                req_ready_d = 1'b1;
            end
        endcase

        if (enter_resp) begin
            rsp_err_d = xfer_err;
            rsp_dat_d = !xfer_err && !xfer_wr;
        end
    end

    // Reset outranks the array access so a pending store never commits.
    assign arr_we = enter_resp && xfer_wr && !xfer_err && !resetl;
    assign arr_re = enter_resp && !xfer_wr && !xfer_err && !resetl;

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge CLK) begin
        if (resetl) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_dat_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            wr_q        <= wr_d;
            err_q       <= err_d;
            idx_q       <= idx_d;
            wdata_q     <= wdata_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_dat_q   <= rsp_dat_d;
        end
    end

    dmem_array #(
        .DEPTH_WORDS (DEPTH_WORDS)
    ) u_array (
        .CLK     (CLK),
        .we_i    (arr_we),
        .waddr_i (xfer_idx),
        .wdata_i (xfer_wdata),
        .re_i    (arr_re),
        .raddr_i (xfer_idx),
        .rdata_o (arr_rdata)
    );

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    // The read register only reloads on a load entering RESP, so gating it
    // with a registered flag gives a stable, clearable response word.
    assign rsp_rdata = {64{rsp_dat_q}} & arr_rdata;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder. Port 0: DEPTH 256, 2 wait states,
// base 0. Port 1: DEPTH 256, no wait states, base 0x1000. Expected values come
// from a word-indexed model of the memory and the address rules.
module tb_dmem_responder;

    logic        CLK;
    logic        resetl;
    logic        req_valid [2];
    logic        req_ready [2];
    logic        req_write [2];
    logic [63:0] req_addr  [2];
    logic [63:0] req_wdata [2];
    logic        rsp_valid [2];
    logic        rsp_ready [2];
    logic [63:0] rsp_rdata [2];
    logic        rsp_err   [2];

    int total = 0;
    int bad   = 0;

    logic [63:0] mdl [longint];

    dmem_responder #(.DEPTH_WORDS(256), .WAIT_STATES(2), .BASE_ADDR(64'h0)) dut0 (
        .CLK(CLK), .resetl(resetl),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_write(req_write[0]),
        .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
        .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
        .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0])
    );

    dmem_responder #(.DEPTH_WORDS(256), .WAIT_STATES(0), .BASE_ADDR(64'h1000)) dut1 (
        .CLK(CLK), .resetl(resetl),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_write(req_write[1]),
        .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
        .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
        .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1])
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    function automatic int ws_of(input int p);
        return (p == 0) ? 2 : 0;
    endfunction

    function automatic logic [63:0] base_of(input int p);
        return (p == 0) ? 64'h0 : 64'h1000;
    endfunction

    function automatic bit exp_err(input int p, input logic [63:0] addr);
        logic [63:0] off;
        off = addr - base_of(p);
        return (addr % 8 != 0) || (off / 8 >= 256);
    endfunction

    function automatic longint key_of(input int p, input logic [63:0] addr);
        return longint'(p) * 1000 + longint'((addr - base_of(p)) / 8);
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic pulse_reset();
        @(negedge CLK);
        resetl = 1'b1;
        repeat (2) @(posedge CLK);
        #1 resetl = 1'b0;
    endtask

    // Present one request, wait for the response, optionally backpressure it
    // for 'hold' cycles while a competing store is offered, then handshake.
    task automatic do_txn(input int p, input bit wr, input logic [63:0] addr,
                          input logic [63:0] wd, input int hold, input bit rdy_high);
        bit          e_err;
        bit          known;
        logic [63:0] e_dat;
        int          k;
        e_err = exp_err(p, addr);
        e_dat = 64'h0;
        known = 1'b1;
        if (!e_err && !wr) begin
            known = mdl.exists(key_of(p, addr));
            if (known) e_dat = mdl[key_of(p, addr)];
        end
        @(negedge CLK);
        req_valid[p] = 1'b1;
        req_write[p] = wr;
        req_addr[p]  = addr;
        req_wdata[p] = wd;
        rsp_ready[p] = rdy_high;
        k = 0;
        while (!req_ready[p] && k < 20) begin
            @(negedge CLK);
            k++;
        end
        check($sformatf("p%0d_acc_ready", p), 64'(req_ready[p]), 64'd1);
        @(posedge CLK);
        #1;
        req_valid[p] = 1'b0;
        req_write[p] = ~wr;
        req_addr[p]  = {$urandom, $urandom};
        req_wdata[p] = {$urandom, $urandom};
        k = 0;
        while (!rsp_valid[p] && k < 40) begin
            @(posedge CLK);
            #1;
            k++;
        end
        check($sformatf("p%0d_latency", p), 64'(k), 64'(1 + ws_of(p)));
        check($sformatf("p%0d_rsp_valid", p), 64'(rsp_valid[p]), 64'd1);
        for (int i = 0; i < hold; i++) begin
            req_valid[p] = 1'b1;
            req_write[p] = 1'b1;
            req_addr[p]  = base_of(p) + 64'h18;
            req_wdata[p] = 64'h5555;
            @(posedge CLK);
            #1;
            check($sformatf("p%0d_hold_valid", p), 64'(rsp_valid[p]), 64'd1);
            check($sformatf("p%0d_hold_ready", p), 64'(req_ready[p]), 64'd0);
            check($sformatf("p%0d_hold_err", p), 64'(rsp_err[p]), 64'(e_err));
            if (known) check($sformatf("p%0d_hold_rdata", p), rsp_rdata[p], e_dat);
        end
        req_valid[p] = 1'b0;
        check($sformatf("p%0d_err@%h", p, addr), 64'(rsp_err[p]), 64'(e_err));
        if (known) check($sformatf("p%0d_rdata@%h", p, addr), rsp_rdata[p], e_dat);
        rsp_ready[p] = 1'b1;
        @(posedge CLK);
        #1;
        rsp_ready[p] = 1'b0;
        check($sformatf("p%0d_post_valid", p), 64'(rsp_valid[p]), 64'd0);
        check($sformatf("p%0d_post_rdata", p), rsp_rdata[p], 64'h0);
        check($sformatf("p%0d_post_err", p), 64'(rsp_err[p]), 64'd0);
        check($sformatf("p%0d_post_ready", p), 64'(req_ready[p]), 64'd1);
        if (wr && !e_err) mdl[key_of(p, addr)] = wd;
    endtask

    // Store on port 0 with reset sampled 'at_edge' edges after the accept edge.
    task automatic reset_store(input logic [63:0] addr, input logic [63:0] wd, input int at_edge);
        @(negedge CLK);
        req_valid[0] = 1'b1;
        req_write[0] = 1'b1;
        req_addr[0]  = addr;
        req_wdata[0] = wd;
        check("rst_acc_ready", 64'(req_ready[0]), 64'd1);
        @(posedge CLK);
        #1;
        req_valid[0] = 1'b0;
        for (int i = 1; i < at_edge; i++) begin
            @(posedge CLK);
            #1;
        end
        resetl = 1'b1;
        @(posedge CLK);
        #1;
        resetl = 1'b0;
        check("rst_rsp_valid", 64'(rsp_valid[0]), 64'd0);
        check("rst_req_ready", 64'(req_ready[0]), 64'd1);
        check("rst_rdata", rsp_rdata[0], 64'h0);
        check("rst_err", 64'(rsp_err[0]), 64'd0);
    endtask

    initial begin
        logic [63:0] a;
        int          p;
        int          r;
        int          hold;
        resetl = 1'b1;
        for (int i = 0; i < 2; i++) begin
            req_valid[i] = 1'b0;
            req_write[i] = 1'b0;
            req_addr[i]  = 64'h0;
            req_wdata[i] = 64'h0;
            rsp_ready[i] = 1'b0;
        end
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        resetl = 1'b0;
        @(negedge CLK);
        for (int i = 0; i < 2; i++) begin
            check($sformatf("p%0d_reset_valid", i), 64'(rsp_valid[i]), 64'd0);
            check($sformatf("p%0d_reset_err", i), 64'(rsp_err[i]), 64'd0);
            check($sformatf("p%0d_reset_rdata", i), rsp_rdata[i], 64'h0);
            check($sformatf("p%0d_reset_ready", i), 64'(req_ready[i]), 64'd1);
        end

        // T1: preload word 5, reset (array keeps contents), then load it.
        do_txn(0, 1'b1, 64'h28, 64'hDEAD_BEEF_0000_0005, 0, 1'b0);
        pulse_reset();
        do_txn(0, 1'b0, 64'h28, 64'h0, 0, 1'b0);

        // T2: store then load.
        do_txn(0, 1'b1, 64'h10, 64'h1234, 0, 1'b0);
        do_txn(0, 1'b0, 64'h10, 64'h0, 0, 1'b0);

        // T3: misaligned store leaves the old word intact.
        do_txn(0, 1'b1, 64'h13, 64'hFF, 0, 1'b0);
        do_txn(0, 1'b0, 64'h10, 64'h0, 0, 1'b0);

        // T4: range edges on both bases, including the wrap below base.
        do_txn(0, 1'b1, 64'h7F8, 64'hCAFE_F00D_0000_00FF, 0, 1'b0);
        do_txn(0, 1'b0, 64'h7F8, 64'h0, 0, 1'b0);
        do_txn(0, 1'b0, 64'h800, 64'h0, 0, 1'b0);
        do_txn(1, 1'b1, 64'h17F8, 64'h0123_4567_89AB_CDEF, 0, 1'b0);
        do_txn(1, 1'b0, 64'h17F8, 64'h0, 0, 1'b0);
        do_txn(1, 1'b0, 64'h0FF8, 64'h0, 0, 1'b0);
        do_txn(1, 1'b0, 64'h1800, 64'h0, 0, 1'b0);
        do_txn(1, 1'b1, 64'h1003, 64'h1, 0, 1'b0);

        // T5: backpressure with a competing store that must be ignored.
        do_txn(0, 1'b1, 64'h18, 64'h77AA, 0, 1'b0);
        do_txn(0, 1'b0, 64'h28, 64'h0, 5, 1'b0);
        do_txn(0, 1'b0, 64'h18, 64'h0, 0, 1'b0);
        do_txn(0, 1'b1, 64'h20, 64'h4242, 0, 1'b1);

        // T6: reset mid-WAIT and on the edge that would enter RESP.
        do_txn(0, 1'b1, 64'h8, 64'h0BAD, 0, 1'b0);
        reset_store(64'h8, 64'hAA, 1);
        do_txn(0, 1'b0, 64'h8, 64'h0, 0, 1'b0);
        reset_store(64'h8, 64'h99, 2);
        do_txn(0, 1'b0, 64'h8, 64'h0, 0, 1'b0);

        // Random phase: prefill a pool of words, then mixed traffic.
        for (int q = 0; q < 2; q++) begin
            for (int w = 0; w < 17; w++) begin
                a = base_of(q) + 64'((w == 16) ? 255 * 8 : w * 8);
                do_txn(q, 1'b1, a, {$urandom, $urandom}, 0, 1'b0);
            end
        end
        for (int n = 0; n < 60; n++) begin
            p = int'($urandom_range(0, 1));
            r = int'($urandom_range(0, 9));
            if (r <= 6) begin
                a = base_of(p) + 64'(8 * $urandom_range(0, 15));
                if ($urandom_range(0, 3) == 0) a = base_of(p) + 64'h7F8;
            end else if (r == 7) begin
                a = base_of(p) + 64'(8 * $urandom_range(0, 15)) + 64'($urandom_range(1, 7));
            end else if (r == 8) begin
                a = base_of(p) + 64'h800 + 64'(8 * $urandom_range(0, 1000));
            end else begin
                a = base_of(p) - 64'(8 * $urandom_range(1, 4));
            end
            hold = int'($urandom_range(0, 2));
            do_txn(p, 1'($urandom_range(0, 1)), a, {$urandom, $urandom}, hold,
                   (hold == 0) && ($urandom_range(0, 1) == 1));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
